// File: rtl/divisor_frecuencia.sv
// divisor_frecuencia: multi-channel programmable clock divider with period/duty reload at period end
module divisor_frecuencia #(
   parameter int WIDTH          = 18,
   parameter int CHANNELS       = 4,
   parameter int DEFAULT_PERIOD = 250000,
   localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock_in,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] enable,
   input  logic                load,
   input  logic [CH_W-1:0]     load_ch,
   input  logic [WIDTH-1:0]    period_in,
   input  logic [WIDTH-1:0]    duty_in,
   output logic [CHANNELS-1:0] y,
   output logic [CHANNELS-1:0] tick
);
   localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PERIOD);
   localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEFAULT_PERIOD / 2);
   localparam logic [WIDTH-1:0] MIN_P = WIDTH'(2);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   // a period below 2 could never show both a wrap and a counting clock
   logic [WIDTH-1:0] period_clamped;
   assign period_clamped = (period_in < MIN_P) ? MIN_P : period_in;

   for (genvar k = 0; k < CHANNELS; k = k + 1) begin : g_ch
      logic [WIDTH-1:0] z, p, h, sp, sh;
      logic             pend, sel, wrap, apply, y_q, tick_q;
      // an out-of-range load_ch matches no channel, so such loads fall away
      assign sel     = load && (load_ch == CH_W'(k));
      assign wrap    = enable[k] && (z == p - ONE);
      assign apply   = pend && (wrap || !enable[k]);
      assign y[k]    = y_q;
      assign tick[k] = tick_q;
      // counter, registered outputs, and shadow handoff only at a wrap or while idle
      always_ff @(posedge clock_in or negedge reset_n) begin
         if (!reset_n) begin
            z      <= '0;
            p      <= DEF_P;
            h      <= DEF_H;
            sp     <= DEF_P;
            sh     <= DEF_H;
            pend   <= 1'b0;
            y_q    <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            z      <= (enable[k] && !wrap) ? z + ONE : '0;
            y_q    <= enable[k] && (z < h);
            tick_q <= wrap;
            if (apply) begin
               p <= sp;
               h <= sh;
            end
            if (sel) begin
               sp   <= period_clamped;
               sh   <= duty_in;
               pend <= 1'b1;
            end else if (apply) begin
               pend <= 1'b0;
            end
         end
      end
   end
endmodule
